gemm_result_checker: RTL

Self-checking result sink at the output end of the GEMM test top. It latches the operand set that the random generator publishes on each `update_pulse` and computes the expected `final_out` row by row with a serial golden MAC. It then compares each result row the GEMM array delivers against that golden value and keeps pass, error and overrun counters for on-chip or simulation readout. It is the consumer counterpart of the operand generator: the generator drives stimulus in, and this block checks results out.

---
 rtl/gemm_pkg.sv | 36 +++
 rtl/gemm_result_checker_golden_mac_row.sv | 52 +++++
 rtl/gemm_result_checker.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/gemm_pkg.sv
// gemm_pkg: shared types and helpers for the GEMM result checker.
//   state_t       : checker FSM state encoding
//   acc_w()       : signed accumulator width for a K-deep MAC
//   reduce_golden : maps a wide golden value onto the result width.
//                   With CHECKER_SATURATE_EN defined it clamps to +/-max;
//                   otherwise it wraps (two's-complement truncation).
package gemm_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_COMPUTE,
      ST_WAIT_RES,
      ST_COMPARE
   } state_t;

   function automatic int unsigned acc_w(input int unsigned wa,
                                         input int unsigned wb,
                                         input int unsigned k);
      return wa + wb + $clog2(k) + 1;
   endfunction

   // Result is sign-extended to 64 bits; callers keep the low w bits.
   function automatic logic signed [63:0] reduce_golden(input logic signed [63:0] v,
                                                        input int unsigned        w);
`ifdef CHECKER_SATURATE_EN
      logic signed [63:0] lim;
      lim = (64'sd1 <<< (w - 1)) - 64'sd1;
      if (v > lim)  return lim;
      if (v < -lim) return -lim;
      return v;
`else
      return (v <<< (64 - w)) >>> (64 - w);
`endif
   endfunction

endpackage

// File: rtl/gemm_result_checker_golden_mac_row.sv
// golden_mac_row: N parallel signed multiply-accumulators.
//   clk, rst   : clock, asynchronous active-low reset
//   clear      : restart the row; accumulator starts from bias or zero
//   init_bias  : on clear, start from bias[n] instead of zero
//   step       : add a * b_row[n] this cycle (may coincide with clear)
//   a          : A scalar for the current k
//   b_row      : B row for the current k
//   bias       : bias vector
//   acc        : accumulated row, ACC_W bits signed per column
module golden_mac_row #(
   parameter int unsigned N               = 1,
   parameter int unsigned DATA_WIDTH_A    = 8,
   parameter int unsigned DATA_WIDTH_B    = 8,
   parameter int unsigned DATA_WIDTH_bias = 8,
   parameter int unsigned ACC_W           = 21
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            clear,
   input  logic                            init_bias,
   input  logic                            step,
   input  logic [DATA_WIDTH_A-1:0]         a,
   input  logic [N-1:0][DATA_WIDTH_B-1:0]  b_row,
   input  logic [N-1:0][DATA_WIDTH_bias-1:0] bias,
   output logic [N-1:0][ACC_W-1:0]         acc
);

   logic signed [ACC_W-1:0]  base [N];
   logic signed [ACC_W-1:0]  prod [N];
   logic [N-1:0][ACC_W-1:0]  acc_d;

   // clear and step together fold the k=0 product into the initial value.
   always_comb begin
      base  = '{default: '0};
      prod  = '{default: '0};
      acc_d = acc;
      for (int unsigned n = 0; n < N; n++) begin
         if (clear)
            base[n] = init_bias ? ACC_W'($signed(bias[n])) : '0;
         else
            base[n] = $signed(acc[n]);
         prod[n]  = step ? ACC_W'($signed(a)) * ACC_W'($signed(b_row[n])) : '0;
         acc_d[n] = base[n] + prod[n];
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) acc <= '0;
      else      acc <= acc_d;
   end

endmodule

// File: rtl/gemm_result_checker.sv
// gemm_result_checker: latches an operand set on update_pulse, computes the
// golden GEMM result one row at a time with a serial MAC, and compares each
// delivered result row against it.
//   clk, rst           : clock, asynchronous active-low reset
//   update_pulse       : new operand set on A/B/bias/bias_en
//   A, B, bias         : operands
//   out_valid,final_out: DUT result row, rows in order 0..M-1
//   busy               : a set is being checked
//   match / mismatch   : per-row verdict pulses (mismatch also on timeout)
//   set_done           : last row of the set resolved
//   pass_cnt, err_cnt, ovr_cnt : saturating counters
// Build option: CHECKER_SATURATE_EN selects saturating golden reduction
// (default is two's-complement truncation).
module gemm_result_checker
   import gemm_pkg::*;
#(
   parameter int unsigned M                 = 1,
   parameter int unsigned N                 = 1,
   parameter int unsigned K                 = 16,
   parameter int unsigned DATA_WIDTH_A      = 8,
   parameter int unsigned DATA_WIDTH_B      = 8,
   parameter int unsigned DATA_WIDTH_bias   = 8,
   parameter int unsigned DATA_WIDTH_output = 8,
   parameter int unsigned TIMEOUT           = 256,
   parameter int unsigned CNT_W             = 16
) (
   input  logic                                    clk,
   input  logic                                    rst,
   input  logic                                    update_pulse,
   input  logic                                    bias_en,
   input  logic [M-1:0][K-1:0][DATA_WIDTH_A-1:0]   A,
   input  logic [K-1:0][N-1:0][DATA_WIDTH_B-1:0]   B,
   input  logic [N-1:0][DATA_WIDTH_bias-1:0]       bias,
   input  logic                                    out_valid,
   input  logic [N-1:0][DATA_WIDTH_output-1:0]     final_out,
   output logic                                    busy,
   output logic                                    match,
   output logic                                    mismatch,
   output logic                                    set_done,
   output logic [CNT_W-1:0]                        pass_cnt,
   output logic [CNT_W-1:0]                        err_cnt,
   output logic [CNT_W-1:0]                        ovr_cnt
);

   localparam int unsigned ACC_W = acc_w(DATA_WIDTH_A, DATA_WIDTH_B, K);
   localparam int unsigned ROW_W = (M > 1) ? $clog2(M) : 1;
   localparam int unsigned KW    = (K > 1) ? $clog2(K) : 1;
   localparam int unsigned TW    = $clog2(TIMEOUT + K + 1);

   state_t state_q, state_d;

   logic [M-1:0][K-1:0][DATA_WIDTH_A-1:0]   a_q;
   logic [K-1:0][N-1:0][DATA_WIDTH_B-1:0]   b_q;
   logic [N-1:0][DATA_WIDTH_bias-1:0]       bias_q;
   logic                                    bias_en_q;
   logic [ROW_W-1:0]                        row_q;
   logic [KW-1:0]                           k_q;
   logic [TW-1:0]                           tcnt_q;
   logic [N-1:0][DATA_WIDTH_output-1:0]     buf_q;
   logic                                    buf_full_q;
   logic [N-1:0][ACC_W-1:0]                 acc;
   logic [N-1:0][DATA_WIDTH_output-1:0]     gold;

   logic row_last, k_last, timeout, all_eq;
   logic resolve, mac_clear, mac_step, capture;
   logic [1:0] ovr_inc;
   logic [CNT_W:0] ovr_sum;

   assign row_last = (row_q == ROW_W'(M - 1));
   assign k_last   = (k_q == KW'(K - 1));
   // Timer runs from COMPUTE entry of the current row.
   assign timeout  = (tcnt_q >= TW'(TIMEOUT));

   always_comb begin
      gold   = '0;
      all_eq = 1'b1;
      for (int unsigned n = 0; n < N; n++) begin
         gold[n] = DATA_WIDTH_output'(reduce_golden(64'($signed(acc[n])), DATA_WIDTH_output));
         if (buf_q[n] != gold[n]) all_eq = 1'b0;
      end
   end

   golden_mac_row #(
      .N              (N),
      .DATA_WIDTH_A   (DATA_WIDTH_A),
      .DATA_WIDTH_B   (DATA_WIDTH_B),
      .DATA_WIDTH_bias(DATA_WIDTH_bias),
      .ACC_W          (ACC_W)
   ) u_mac (
      .clk      (clk),
      .rst      (rst),
      .clear    (mac_clear),
      .init_bias(bias_en_q),
      .step     (mac_step),
      .a        (a_q[row_q][k_q]),
      .b_row    (b_q[k_q]),
      .bias     (bias_q),
      .acc      (acc)
   );

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= ST_IDLE;
      else      state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE:     if (update_pulse) state_d = ST_COMPUTE;
         ST_COMPUTE:  if (k_last) state_d = ST_WAIT_RES;
         ST_WAIT_RES: begin
            if (buf_full_q)   state_d = ST_COMPARE;
            else if (timeout) state_d = row_last ? ST_IDLE : ST_COMPUTE;
         end
         ST_COMPARE:  state_d = row_last ? ST_IDLE : ST_COMPUTE;
         default:     state_d = ST_IDLE;
      endcase
   end

   // Output / control logic
   always_comb begin
      busy      = (state_q != ST_IDLE);
      match     = (state_q == ST_COMPARE) && all_eq;
      mismatch  = ((state_q == ST_COMPARE) && !all_eq) ||
                  ((state_q == ST_WAIT_RES) && !buf_full_q && timeout);
      resolve   = (state_q == ST_COMPARE) ||
                  ((state_q == ST_WAIT_RES) && !buf_full_q && timeout);
      set_done  = resolve && row_last;
      mac_step  = (state_q == ST_COMPUTE);
      mac_clear = (state_q == ST_COMPUTE) && (k_q == '0);
      // Buffer clears in COMPARE, so a row arriving then is taken, not overrun.
      capture   = out_valid && (state_q != ST_IDLE) &&
                  (!buf_full_q || state_q == ST_COMPARE);
      ovr_inc   = 2'(out_valid && !capture) + 2'(update_pulse && state_q != ST_IDLE);
   end

   // Operand latch, sequencing counters and result buffer
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         a_q        <= '0;
         b_q        <= '0;
         bias_q     <= '0;
         bias_en_q  <= 1'b0;
         row_q      <= '0;
         k_q        <= '0;
         tcnt_q     <= '0;
         buf_q      <= '0;
         buf_full_q <= 1'b0;
      end else begin
         if (state_q == ST_IDLE && update_pulse) begin
            a_q       <= A;
            b_q       <= B;
            bias_q    <= bias;
            bias_en_q <= bias_en;
            row_q     <= '0;
         end else if (resolve && !row_last) begin
            row_q <= row_q + 1'b1;
         end

         if (state_q == ST_COMPUTE) k_q <= k_last ? '0 : k_q + 1'b1;
         else                       k_q <= '0;

         if (state_q == ST_IDLE || resolve) tcnt_q <= '0;
         else                               tcnt_q <= tcnt_q + 1'b1;

         if (capture) begin
            buf_q      <= final_out;
            buf_full_q <= 1'b1;
         end else if (state_q == ST_COMPARE) begin
            buf_full_q <= 1'b0;
         end
      end
   end

   // Saturating counters
   assign ovr_sum = {1'b0, ovr_cnt} + (CNT_W + 1)'(ovr_inc);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pass_cnt <= '0;
         err_cnt  <= '0;
         ovr_cnt  <= '0;
      end else begin
         if (match && pass_cnt != '1)   pass_cnt <= pass_cnt + 1'b1;
         if (mismatch && err_cnt != '1) err_cnt  <= err_cnt + 1'b1;
         ovr_cnt <= ovr_sum[CNT_W] ? '1 : ovr_sum[CNT_W-1:0];
      end
   end

endmodule
